// File: rtl/if_id_stage_if.sv
// IF/ID pipeline-register bundle: fetch-side inputs, hazard controls and the
// registered values presented to decode.
interface if_id_stage_if;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        hold_i;
  logic        flush_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic [1:0]  state_o;
  logic        stall_err_o;

  modport master (
    output pc_i, instr_i, hold_i, flush_i,
    input  pc_o, instr_o, valid_o, state_o, stall_err_o
  );

  modport slave (
    input  pc_i, instr_i, hold_i, flush_i,
    output pc_o, instr_o, valid_o, state_o, stall_err_o
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with hold/flush control, stall watchdog and optional
// hold/flush performance counters (enabled by defining IFID_PERF_CNT_EN).
module if_id_stage #(
  parameter int unsigned MAX_STALL = 4  // legal range 1..6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  if_id_stage_if.slave  bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o,
  output logic [15:0]   flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_BUBBLE = 2'b10
  } state_t;

  localparam logic [2:0] HOLD_SAT   = 3'd7;
  localparam logic [2:0] HOLD_LIMIT = 3'(MAX_STALL);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [2:0]  r_hold_cnt;
  logic        r_stall_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_pc        <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_hold_cnt  <= '0;
      r_stall_err <= 1'b0;
    end else if (bus.hold_i) begin
      // Hold masks any simultaneous flush; the stored instruction stays put.
      r_state <= ST_STALL;
      if (r_hold_cnt != HOLD_SAT) begin
        r_hold_cnt <= r_hold_cnt + 3'd1;
      end
      if (r_hold_cnt == HOLD_LIMIT) begin
        r_stall_err <= 1'b1;
      end
    end else if (bus.flush_i) begin
      r_state    <= ST_BUBBLE;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= ST_RUN;
      r_pc       <= bus.pc_i;
      r_instr    <= bus.instr_i;
      r_valid    <= 1'b1;
      r_hold_cnt <= '0;
    end
  end

  assign bus.pc_o        = r_pc;
  assign bus.instr_o     = r_instr;
  assign bus.valid_o     = r_valid;
  assign bus.state_o     = r_state;
  assign bus.stall_err_o = r_stall_err;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Flushes masked by a hold are counted as hold cycles only.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.hold_i) begin
      if (r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end else if (bus.flush_i) begin
      if (r_flush_cnt != 16'hFFFF) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes model expectations per
// edge, an independent monitor pops and compares after each rising edge.
module tb_if_id_stage;
  localparam int MAX_STALL = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  if_id_stage_if bus ();

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  if_id_stage #(.MAX_STALL(MAX_STALL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  state;
    logic        err;
    int          scnt;
    int          fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: what decode should see after each edge.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err;
  logic [1:0]  m_state;
  int          m_run, m_scnt, m_fcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic hold, input logic flush,
                       input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    @(negedge clk_i);
    rst_i       = rst;
    bus.hold_i  = hold;
    bus.flush_i = flush;
    bus.pc_i    = pc;
    bus.instr_i = instr;
    if (!rst) begin
      m_pc = '0; m_instr = '0; m_valid = 1'b0; m_state = 2'b00;
      m_err = 1'b0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    end else if (hold) begin
      m_run++;
      if (m_run > MAX_STALL) m_err = 1'b1;
      m_state = 2'b01;
      if (m_scnt < 65535) m_scnt++;
    end else if (flush) begin
      m_run = 0;
      m_instr = '0; m_valid = 1'b0; m_state = 2'b10;
      if (m_fcnt < 65535) m_fcnt++;
    end else begin
      m_run = 0;
      m_pc = pc; m_instr = instr; m_valid = 1'b1; m_state = 2'b00;
    end
    e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.state = m_state;
    e.err = m_err; e.scnt = m_scnt; e.fcnt = m_fcnt;
    sb_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_o",        bus.pc_o,                 e.pc);
        check("instr_o",     bus.instr_o,              e.instr);
        check("valid_o",     32'(bus.valid_o),         32'(e.valid));
        check("state_o",     32'(bus.state_o),         32'(e.state));
        check("stall_err_o", 32'(bus.stall_err_o),     32'(e.err));
`ifdef IFID_PERF_CNT_EN
        check("stall_cnt_o", 32'(stall_cnt_o),         32'(e.scnt));
        check("flush_cnt_o", 32'(flush_cnt_o),         32'(e.fcnt));
`endif
      end
    end
  end

  // Driver
  initial begin
    logic h, f, r;
    rst_i = 1'b0; bus.hold_i = 1'b0; bus.flush_i = 1'b0;
    bus.pc_i = '0; bus.instr_i = '0;

    // Reset with hold asserted
    drive(0, 1, 0, 32'h0, 32'h8C02_0004);
    drive(0, 1, 0, 32'h0, 32'h8C02_0004);
    // Load, load-use stall, release
    drive(1, 0, 0, 32'h0000_0004, 32'h0043_2020);
    drive(1, 1, 0, 32'h0000_0008, 32'h0062_2822);
    drive(1, 0, 0, 32'h0000_0008, 32'h0062_2822);
    // Flush masked by hold, then flush applied, then back-to-back flush
    drive(1, 1, 1, 32'h0000_000C, 32'h1111_1111);
    drive(1, 0, 1, 32'h0000_000C, 32'h1111_1111);
    drive(1, 0, 1, 32'h0000_0010, 32'h2222_2222);
    // Watchdog: four holds are legal, the fifth trips the sticky flag
    drive(1, 0, 0, 32'h0000_0014, 32'h3333_3333);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 32'h100 + 32'(i), 32'hDEAD_0000 + 32'(i));
    drive(1, 0, 0, 32'h0000_0018, 32'h4444_4444);
    drive(1, 0, 0, 32'h0000_001C, 32'h5555_5555);
    // Reset mid-stall clears stall and counter
    drive(1, 1, 0, 32'h0000_0020, 32'h6666_6666);
    drive(0, 1, 1, 32'h0000_0020, 32'h6666_6666);
    drive(1, 0, 0, 32'h0000_0024, 32'h7777_7777);
    // 3 holds, 2 unmasked flushes, 1 masked flush
    drive(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 32'h40, 32'h8888_8888);
    drive(1, 0, 1, 32'h44, 32'h9999_9999);
    drive(1, 0, 1, 32'h48, 32'hAAAA_AAAA);
    drive(1, 1, 1, 32'h4C, 32'hBBBB_BBBB);
    drive(1, 0, 0, 32'h50, 32'hCCCC_CCCC);

    // Randomized traffic with bursty holds
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) >= 3);
      h = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 30);
      drive(r, h, f, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk_i);
    #2;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
